// File: rtl/mini_tpu_pkg.sv
// mini_tpu_pkg
// Shared definitions for the mini_tpu 4x4 int8 matrix-multiply block:
// matrix geometry, RAM region bases, the controller state enum and the
// function that reduces a 32-bit accumulator to the stored result byte.
// Optional feature macro: MINI_TPU_SATURATE_EN (clamp instead of wrap).
package mini_tpu_pkg;

  localparam int N      = 4;
  localparam int A_BASE = 0;
  localparam int B_BASE = 16;
  localparam int C_BASE = 32;

  typedef enum logic [1:0] {
    IDLE,
    COMPUTE,
    WRITE,
    DONE
  } state_t;

  // Reduce the accumulator to one result byte. With saturation enabled the
  // value is clamped to the int8 range, otherwise the low byte is kept.
  function automatic logic [7:0] result_byte(input logic signed [31:0] acc);
`ifdef MINI_TPU_SATURATE_EN
    if (acc > 32'sd127) begin
      return 8'h7F;
    end else if (acc < -32'sd128) begin
      return 8'h80;
    end else begin
      return acc[7:0];
    end
`else
    return acc[7:0];
`endif
  endfunction

endpackage

// File: rtl/mini_tpu_mac.sv
// mini_tpu_mac
// Signed 8x8 multiply feeding a 32-bit accumulate register.
// Ports:
//   clk, rst : clock and synchronous active-high reset
//   en       : perform one MAC step this cycle
//   clear    : first term of a dot product, load product instead of adding
//   a, b     : signed int8 operands
//   acc      : accumulator value (signed, 32 bits)
module mini_tpu_mac (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic        clear,
  input  logic [7:0]  a,
  input  logic [7:0]  b,
  output logic [31:0] acc
);

  logic signed [15:0] product;
  logic signed [31:0] acc_q;

  assign product = $signed(a) * $signed(b);
  assign acc     = acc_q;

  // The accumulator restarts on the first term of each dot product so no
  // separate clear cycle is needed between output elements.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q <= '0;
    end else if (en) begin
      if (clear) begin
        acc_q <= 32'(product);
      end else begin
        acc_q <= acc_q + 32'(product);
      end
    end
  end

endmodule

// File: rtl/mini_tpu.sv
// mini_tpu
// 4x4 signed int8 matrix multiply C = A*B over a shared 64x8 RAM.
// A lives at 0..15, B at 16..31, C is written to 32..47, 48..63 is scratch.
// Optional feature macro: MINI_TPU_SATURATE_EN (clamp result bytes).
// Ports:
//   clk, rst       : clock and synchronous active-high reset
//   start          : begin a run (accepted only in IDLE or DONE)
//   done           : high while in DONE
//   cpu_write_*    : host write port (honoured only in IDLE or DONE)
//   result_out     : row 0 of C, C[0][j] in bits [8j+7:8j]
module mini_tpu
  import mini_tpu_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  output logic                  done,
  input  logic [ADDR_WIDTH-1:0] cpu_write_addr,
  input  logic [DATA_WIDTH-1:0] cpu_write_data,
  input  logic                  cpu_write_en,
  output logic [31:0]           result_out
);

  logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

  state_t state, state_next;
  logic [1:0] i_idx, j_idx, k_idx;
  logic mac_en, mac_clear, eng_we, host_we, start_ok;
  logic [ADDR_WIDTH-1:0] a_addr, b_addr, c_addr;
  logic [31:0] acc;
  logic [7:0]  c_byte;

  assign a_addr = ADDR_WIDTH'(A_BASE + N * int'(i_idx) + int'(k_idx));
  assign b_addr = ADDR_WIDTH'(B_BASE + N * int'(k_idx) + int'(j_idx));
  assign c_addr = ADDR_WIDTH'(C_BASE + N * int'(i_idx) + int'(j_idx));
  assign c_byte = result_byte(acc);

  mini_tpu_mac u_mac (
    .clk   (clk),
    .rst   (rst),
    .en    (mac_en),
    .clear (mac_clear),
    .a     (mem[a_addr]),
    .b     (mem[b_addr]),
    .acc   (acc)
  );

  // Controller state register; reset aborts any run straight back to IDLE.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic: four MAC cycles then one write cycle per element,
  // finishing after element (3,3).
  always_comb begin
    state_next = state;
    case (state)
      IDLE, DONE: if (start) state_next = COMPUTE;
      COMPUTE:    if (k_idx == 2'd3) state_next = WRITE;
      WRITE:      state_next = (i_idx == 2'd3 && j_idx == 2'd3) ? DONE : COMPUTE;
      default:    state_next = IDLE;
    endcase
  end

  // Output decode: the engine owns the RAM write port only in WRITE, and
  // the host only while the block is not busy.
  always_comb begin
    done      = (state == DONE);
    mac_en    = (state == COMPUTE);
    mac_clear = (k_idx == 2'd0);
    eng_we    = (state == WRITE);
    start_ok  = start && (state == IDLE || state == DONE);
    host_we   = cpu_write_en && (state == IDLE || state == DONE);
  end

  // Loop counters and the row-0 result register. k wraps naturally to 0
  // after the last MAC, so WRITE only has to advance j and i.
  always_ff @(posedge clk) begin
    if (rst) begin
      i_idx      <= '0;
      j_idx      <= '0;
      k_idx      <= '0;
      result_out <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start_ok) begin
            i_idx <= '0;
            j_idx <= '0;
            k_idx <= '0;
          end
        end
        COMPUTE: k_idx <= k_idx + 2'd1;
        WRITE: begin
          j_idx <= j_idx + 2'd1;
          if (j_idx == 2'd3) i_idx <= i_idx + 2'd1;
          if (i_idx == 2'd0) result_out[8*j_idx +: 8] <= c_byte;
        end
        default: ;
      endcase
    end
  end

  // Single RAM write port. Contents are deliberately not reset so a reset
  // mid-run leaves the partially written C bytes in place.
  always_ff @(posedge clk) begin
    if (eng_we) begin
      mem[c_addr] <= c_byte;
    end else if (host_we) begin
      mem[cpu_write_addr] <= cpu_write_data;
    end
  end

endmodule

// File: tb/tb_mini_tpu.sv
// tb_mini_tpu
// Scoreboard bench for mini_tpu: each start pushes the expected row 0,
// C region and completion edge; a monitor pops on the rising edge of done.
module tb_mini_tpu;
  import mini_tpu_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        done;
  logic [5:0]  cpu_write_addr;
  logic [7:0]  cpu_write_data;
  logic        cpu_write_en;
  logic [31:0] result_out;

  mini_tpu dut (
    .clk            (clk),
    .rst            (rst),
    .start          (start),
    .done           (done),
    .cpu_write_addr (cpu_write_addr),
    .cpu_write_data (cpu_write_data),
    .cpu_write_en   (cpu_write_en),
    .result_out     (result_out)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0]  row0;
    logic [127:0] cb;
    logic [31:0]  accept_edge;
  } exp_t;

  exp_t sb[$];
  int compared   = 0;
  int mismatched = 0;
  int edge_count = 0;
  logic done_prev = 1'b0;
  logic signed [7:0] ma[16];
  logic signed [7:0] mb[16];

  // Count rising edges so latency can be measured in clock edges.
  always @(posedge clk) edge_count++;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] ref_byte(input int v);
`ifdef MINI_TPU_SATURATE_EN
    if (v > 127) return 8'h7F;
    if (v < -128) return 8'h80;
`endif
    return v[7:0];
  endfunction

  // Reference model: plain triple loop over the matrices held in the bench.
  function automatic exp_t model();
    exp_t e;
    e = '0;
    for (int i = 0; i < 4; i++) begin
      for (int j = 0; j < 4; j++) begin
        int s;
        logic [7:0] b;
        s = 0;
        for (int k = 0; k < 4; k++) s += int'(ma[4*i+k]) * int'(mb[4*k+j]);
        b = ref_byte(s);
        e.cb[8*(4*i+j) +: 8] = b;
        if (i == 0) e.row0[8*j +: 8] = b;
      end
    end
    return e;
  endfunction

  // Monitor: whenever done rises, compare against the oldest expectation.
  always @(negedge clk) begin
    if (!rst && done && !done_prev) begin
      if (sb.size() == 0) begin
        checkOutput("unexpected_done", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        checkOutput("row0", result_out, e.row0);
        checkOutput("latency", 32'(edge_count) - e.accept_edge, 32'd80);
        for (int n = 0; n < 16; n++)
          checkOutput($sformatf("c_byte%0d", n), 32'(dut.mem[32+n]), 32'(e.cb[8*n +: 8]));
      end
    end
    done_prev = done;
  end

  task automatic host_write(input int addr, input logic [7:0] data);
    cpu_write_en   = 1'b1;
    cpu_write_addr = 6'(addr);
    cpu_write_data = data;
    @(negedge clk);
    cpu_write_en   = 1'b0;
  endtask

  task automatic pulse_start(input bit expect_run);
    if (expect_run) begin
      exp_t e;
      e = model();
      e.accept_edge = 32'(edge_count + 1);
      sb.push_back(e);
    end
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Load A and B, then start; optionally the last B write shares the start cycle.
  task automatic applyStimulus(input bit overlap);
    for (int n = 0; n < 16; n++) host_write(n, ma[n]);
    for (int n = 0; n < 15; n++) host_write(16 + n, mb[n]);
    if (overlap) begin
      cpu_write_en   = 1'b1;
      cpu_write_addr = 6'd31;
      cpu_write_data = mb[15];
      pulse_start(1'b1);
      cpu_write_en   = 1'b0;
    end else begin
      host_write(31, mb[15]);
      pulse_start(1'b1);
    end
  endtask

  task automatic wait_idle(input int budget);
    int c;
    c = 0;
    while (sb.size() != 0 && c < budget) begin
      @(negedge clk);
      c++;
    end
    if (sb.size() != 0) begin
      checkOutput("timeout", 32'(sb.size()), 32'd0);
      sb.delete();
    end
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; cpu_write_en = 1'b0;
    cpu_write_addr = '0; cpu_write_data = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    checkOutput("reset_done", 32'(done), 32'd0);
    checkOutput("reset_result", result_out, 32'd0);
    checkOutput("reset_state", 32'(dut.state), 32'(IDLE));

    $display("[TB] directed: ones with k=3 zeroed");
    for (int n = 0; n < 16; n++) begin
      ma[n] = ((n % 4) < 3) ? 8'sd1 : 8'sd0;
      mb[n] = 8'sd1;
    end
    applyStimulus(1'b0);
    wait_idle(200);
    checkOutput("t1_const", result_out, 32'h03030303);

    $display("[TB] directed: identity times counting B");
    for (int n = 0; n < 16; n++) begin
      ma[n] = (n / 4 == n % 4) ? 8'sd1 : 8'sd0;
      mb[n] = 8'(n + 1);
    end
    applyStimulus(1'b1);
    wait_idle(200);
    checkOutput("t2_const", result_out, 32'h04030201);

    $display("[TB] directed: 0x7F times 0x7F");
    for (int n = 0; n < 16; n++) begin ma[n] = 8'sh7F; mb[n] = 8'sh7F; end
    applyStimulus(1'b0);
    wait_idle(200);
`ifdef MINI_TPU_SATURATE_EN
    checkOutput("t3_const", result_out, 32'h7F7F7F7F);
`else
    checkOutput("t3_const", result_out, 32'h04040404);
`endif

    $display("[TB] directed: 0x80 times 0x7F");
    for (int n = 0; n < 16; n++) begin ma[n] = -8'sd128; mb[n] = 8'sh7F; end
    applyStimulus(1'b0);
    wait_idle(200);
`ifdef MINI_TPU_SATURATE_EN
    checkOutput("t4_const", result_out, 32'h80808080);
`else
    checkOutput("t4_const", result_out, 32'h00000000);
`endif

    $display("[TB] busy: host write and start ignored mid-run");
    for (int n = 0; n < 16; n++) begin ma[n] = 8'($urandom); mb[n] = 8'($urandom); end
    applyStimulus(1'b0);
    repeat (20) @(negedge clk);
    host_write(0, 8'hFF);
    pulse_start(1'b0);
    wait_idle(200);
    checkOutput("a0_kept", 32'(dut.mem[0]), 32'(ma[0]));
    pulse_start(1'b1);
    wait_idle(200);

    $display("[TB] reset mid-run");
    for (int n = 0; n < 16; n++) begin ma[n] = 8'($urandom); mb[n] = 8'($urandom); end
    applyStimulus(1'b0);
    while (edge_count < int'(sb[0].accept_edge) + 29) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    sb.delete();
    checkOutput("rst_done", 32'(done), 32'd0);
    checkOutput("rst_result", result_out, 32'd0);
    checkOutput("rst_state", 32'(dut.state), 32'(IDLE));
    pulse_start(1'b1);
    wait_idle(200);

    $display("[TB] random runs");
    for (int r = 0; r < 4; r++) begin
      for (int n = 0; n < 16; n++) begin ma[n] = 8'($urandom); mb[n] = 8'($urandom); end
      host_write(48 + int'($urandom_range(0, 15)), 8'($urandom));
      applyStimulus(r[0]);
      wait_idle(200);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
